// File: rtl/square_wave_gen.sv
// rtl/square_wave_gen.sv - programmable square-wave generator with independent high/low lengths
//
// Purpose: squareOut is high for m time units, then low for n time units, and
// repeats. One time unit is TICK_DIV clock cycles. Each phase length is
// captured when that phase starts, so changing m or n only affects the next
// phase of that type.
//
// Ports:
//   clk       - system clock, rising edge active
//   reset     - asynchronous active-low reset
//   m         - high-phase length in time units
//   n         - low-phase length in time units
//   squareOut - registered square-wave output
module square_wave_gen #(
    parameter int TICK_DIV = 10,
    parameter int W        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] m,
    input  logic [W-1:0] n,
    output logic         squareOut
);

    // The counter must reach the longest phase, (2^W-1)*TICK_DIV-1.
    localparam int MAX_CYC = ((2 ** W) - 1) * TICK_DIV;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] term;
    logic          start;

    logic [CW-1:0] m_term;
    logic [CW-1:0] n_term;
    logic          m_nz;
    logic          n_nz;
    logic          go_off;

    // Terminal counts for a phase. A value is used only when its length is
    // nonzero, so the wrap for a length of 0 does not matter.
    always_comb begin
        m_nz   = (m != '0);
        n_nz   = (n != '0);
        m_term = CW'(m) * CW'(TICK_DIV) - CW'(1);
        n_term = CW'(n) * CW'(TICK_DIV) - CW'(1);
        // When an ON phase ends, the next phase is OFF if n allows it.
        // When starting from OFF or idle, the next phase is ON if m allows it.
        if (state == ON) begin
            go_off = n_nz;
        end else begin
            go_off = !m_nz && n_nz;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= OFF;
            squareOut <= 1'b0;
            cnt       <= '0;
            term      <= '0;
            start     <= 1'b1;
        end else if (start || (cnt == term)) begin
            // A phase boundary. With start set (after reset, or while both
            // lengths are zero) this branch runs every cycle, so m and n are
            // re-sampled until one of them becomes nonzero.
            cnt <= '0;
            if (go_off) begin
                state     <= OFF;
                squareOut <= 1'b0;
                term      <= n_term;
                start     <= 1'b0;
            end else if (m_nz) begin
                state     <= ON;
                squareOut <= 1'b1;
                term      <= m_term;
                start     <= 1'b0;
            end else begin
                state     <= OFF;
                squareOut <= 1'b0;
                term      <= '0;
                start     <= 1'b1;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// tb/tb_square_wave_gen.sv - scoreboard bench for square_wave_gen (TICK_DIV=10 and TICK_DIV=1)
module tb_square_wave_gen;

    typedef struct {
        bit level;
        int len;   // -1: check level only (partial run)
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] m = 4'd0;
    logic [3:0] n = 4'd0;
    logic       sq_a;
    logic       sq_b;

    int   total = 0;
    int   bad = 0;
    bit   arm = 1'b0;
    seg_t qa[$];
    seg_t qb[$];

    always #5 clk = ~clk;

    square_wave_gen #(.TICK_DIV(10), .W(4)) dut_a (
        .clk(clk), .reset(reset), .m(m), .n(n), .squareOut(sq_a)
    );

    square_wave_gen #(.TICK_DIV(1), .W(4)) dut_b (
        .clk(clk), .reset(reset), .m(m), .n(n), .squareOut(sq_b)
    );

    // Monitors: measure each run of constant output and compare the finished
    // run with the next expected segment.
    bit  act_a = 1'b0;
    bit  prev_a;
    int  run_a;
    always @(negedge clk) begin
        if (!arm) begin
            act_a = 1'b0;
        end else if (!act_a) begin
            act_a  = 1'b1;
            prev_a = sq_a;
            run_a  = 1;
        end else if (sq_a == prev_a) begin
            run_a++;
        end else begin
            if (qa.size() > 0) begin
                seg_t e;
                e = qa.pop_front();
                total++;
                if (e.level != prev_a || (e.len >= 0 && e.len != run_a)) begin
                    bad++;
                    $display("FAIL run_a: got level=%0d len=%0d, expected level=%0d len=%0d",
                             prev_a, run_a, e.level, e.len);
                end
            end
            prev_a = sq_a;
            run_a  = 1;
        end
    end

    bit  act_b = 1'b0;
    bit  prev_b;
    int  run_b;
    always @(negedge clk) begin
        if (!arm) begin
            act_b = 1'b0;
        end else if (!act_b) begin
            act_b  = 1'b1;
            prev_b = sq_b;
            run_b  = 1;
        end else if (sq_b == prev_b) begin
            run_b++;
        end else begin
            if (qb.size() > 0) begin
                seg_t e;
                e = qb.pop_front();
                total++;
                if (e.level != prev_b || (e.len >= 0 && e.len != run_b)) begin
                    bad++;
                    $display("FAIL run_b: got level=%0d len=%0d, expected level=%0d len=%0d",
                             prev_b, run_b, e.level, e.len);
                end
            end
            prev_b = sq_b;
            run_b  = 1;
        end
    end

    task automatic push_a(input bit lvl, input int len);
        qa.push_back('{lvl, len});
    endtask

    task automatic push_b(input bit lvl, input int len);
        qb.push_back('{lvl, len});
    endtask

    // Hold reset, load m/n, optionally arm the monitors, release at a falling edge.
    task automatic restart(input logic [3:0] mm, input logic [3:0] nn, input bit watch);
        @(negedge clk);
        arm   = 1'b0;
        reset = 1'b0;
        m     = mm;
        n     = nn;
        repeat (3) @(negedge clk);
        if (watch) begin
            @(posedge clk);
            arm = 1'b1;
            push_a(1'b0, -1);
            push_b(1'b0, -1);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((qa.size() > 0 || qb.size() > 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, pending a=%0d b=%0d, expected 0 0", name, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic hold_check(input string name, input bit lvl, input int cycles);
        int errs = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (sq_a != lvl) errs++;
            if (sq_b != lvl) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s: %0d samples differ from required level %0d", name, errs, lvl);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    initial begin
        // Reset value
        #3;
        check_bit("reset_a", sq_a, 1'b0);
        check_bit("reset_b", sq_b, 1'b0);

        // Basic 30/20 over four periods
        restart(4'd3, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_a(1'b1, 30);
            push_a(1'b0, 20);
        end
        drain("basic", 400);

        // Asynchronous reset between edges, mid-ON
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        arm   = 1'b0;
        reset = 1'b0;
        #1;
        check_bit("async_a", sq_a, 1'b0);
        check_bit("async_b", sq_b, 1'b0);

        // Fresh full phase after reset, then mid-phase change of m
        restart(4'd3, 4'd2, 1'b1);
        push_a(1'b1, 30);
        push_a(1'b0, 20);
        drain("after_reset", 200);
        push_a(1'b1, 30);
        push_a(1'b0, 20);
        push_a(1'b1, 50);
        push_a(1'b0, 20);
        repeat (5) @(negedge clk);
        m = 4'd5;
        drain("mid_change", 300);

        // Extremes
        restart(4'd15, 4'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            push_a(1'b1, 150);
            push_a(1'b0, 10);
        end
        drain("m15_n1", 600);

        restart(4'd1, 4'd15, 1'b1);
        for (int i = 0; i < 2; i++) begin
            push_a(1'b1, 10);
            push_a(1'b0, 150);
        end
        drain("m1_n15", 600);

        // Zero lengths
        restart(4'd0, 4'd5, 1'b0);
        hold_check("m0_n5", 1'b0, 120);
        restart(4'd4, 4'd0, 1'b0);
        @(negedge clk);
        hold_check("m4_n0", 1'b1, 120);
        restart(4'd0, 4'd0, 1'b0);
        hold_check("m0_n0", 1'b0, 40);

        // Leave the idle state by setting m=2, n=2
        @(posedge clk);
        arm = 1'b1;
        push_a(1'b0, -1);
        push_b(1'b0, -1);
        @(negedge clk);
        m = 4'd2;
        n = 4'd2;
        for (int i = 0; i < 2; i++) begin
            push_a(1'b1, 20);
            push_a(1'b0, 20);
        end
        @(negedge clk);
        @(negedge clk);
        check_bit("idle_exit", sq_a, 1'b1);
        drain("m2_n2", 200);

        // TICK_DIV=1 instance, plus the TICK_DIV=10 instance on the same inputs
        restart(4'd2, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_b(1'b1, 2);
            push_b(1'b0, 3);
        end
        push_a(1'b1, 20);
        push_a(1'b0, 30);
        drain("td1", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
